pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Inverse companion of the one-pulse generator: converts single-cycle request pulses back into clean level pulses of programmable length.
- Sits between pulse-producing control logic (button one-pulse, FSM strobes) and slow consumers: LED drivers, 7-seg blank, handshakes to slower domains.
- Never loses pulses: in queue mode, pulses arriving while busy are counted and replayed, each as its own stretched pulse separated by a gap.

Parameters:
LW, 8, width of len/gap and of the internal down-counter
PW, 4, width of the pending-pulse counter; saturates at 2^PW-1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
pulse_in  in  1  trigger; each high cycle counts as one trigger
len  in  LW  high-phase length in cycles; 0 treated as 1
gap  in  LW  low-phase length between replayed pulses; 0 treated as 1
retrig  in  1  1 = retrigger mode, 0 = queue mode
ovf_clr  in  1  clears sticky ovf
out  out  1  stretched pulse, registered
busy  out  1  high when state != IDLE, registered
pending  out  PW  queued triggers not yet emitted
ovf  out  1  sticky: a trigger was dropped because pending was saturated

Behaviour:
- Reset (rst high at a clock edge) dominates everything: state=IDLE, cnt=0, pending=0, out=0, busy=0, ovf=0. Mid-pulse reset aborts; out is 0 on the next cycle.
- FSM states: IDLE, HIGH, GAP.
- IDLE, out=0:
  - pulse_in=1 -> HIGH; cnt loaded with max(len,1).
  - Latency: pulse_in high at edge t -> out=1 from cycle t+1 for exactly max(len,1) cycles.
- HIGH, out=1:
  - cnt decrements each cycle.
  - At cnt==1 -> GAP; cnt loaded with max(gap,1).
  - len changes during HIGH have no effect; the value is latched on entry.
- GAP, out=0:
  - cnt decrements each cycle.
  - At cnt==1: if pending>0 or pulse_in=1 -> HIGH with reload of len; otherwise -> IDLE.
  - Leaving GAP for HIGH with pending>0 decrements pending. A same-cycle pulse_in is queued, so net pending is unchanged.
  - If pending==0 and pulse_in=1, the pulse is consumed directly.
- Minimum gap of 1 cycle guarantees successive pulses are always separable.
- Queue mode (retrig=0): pulse_in in HIGH or GAP (except the consume case above) increments pending.
  - If pending==2^PW-1, pending stays saturated and ovf is set.
- Retrigger mode (retrig=1):
  - pulse_in in HIGH reloads cnt with max(len,1); out stays high continuously and pending is unchanged.
  - pulse_in in GAP sets pending to max(pending,1); it does not accumulate.
- retrig is sampled every cycle. Switching modes does not alter existing pending; queued triggers still replay.
- ovf_clr clears ovf. If a drop and ovf_clr occur in the same cycle, set wins.
- busy = (state != IDLE), registered alongside state. busy is 1 during GAP even though out=0.
- pending is never decremented below 0; it changes only by ±1 per cycle, or is held.

Decomposition:
- Shared package pulse_pkg:
  - state encoding constants S_IDLE=0, S_HIGH=1, S_GAP=2 (2-bit).
  - helper function for max(x,1) at width LW.
- One natural sub-module: pend_counter, a saturating up/down counter (inc, dec, sat flag, PW parameter). It is reused by other event-queue blocks.
- The FSM and cnt stay in the top level.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then idle 5 cycles -> out=0, busy=0, pending=0, ovf=0 throughout.
- Single pulse, len=3, gap=2: pulse_in at edge t -> out=1 on cycles t+1..t+3, busy=1 through t+5, busy=0 at t+6.
- Queue mode, len=2, gap=1: three pulses at t, t+1, t+2 -> pending peaks at 2; out pattern from t+1 is 1,1,0,1,1,0,1,1,0; pending returns to 0.
- Retrigger, len=4: pulses at t and t+3 -> out=1 continuously t+1..t+7; pending=0.
- Overflow, PW=2, len=10: 5 pulses during HIGH -> pending saturates at 3, ovf=1; ovf_clr then clears it; exactly 4 pulses are emitted in total.
- Edge cases:
  - len=0, gap=0 -> behaves as 1-cycle high, 1-cycle gap.
  - rst asserted mid-HIGH -> out=0 next cycle, pending=0.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and the
// "zero means one" length helper used for both high and gap phases.
package pulse_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // A programmed length of 0 is treated as 1 so every phase lasts at least one cycle.
    function automatic int unsigned max1(input int unsigned x);
        return (x == 0) ? 1 : x;
    endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down event counter. Simultaneous inc and dec cancel out;
// it never wraps above all-ones nor below zero.
module pend_counter #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [PW-1:0] o_count,
    output logic          o_sat
);

    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !o_sat) begin
            r_count <= r_count + ONE;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_count = r_count;
    assign o_sat   = &r_count;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into level pulses of programmable length,
// either queueing triggers that arrive while busy or retriggering the high phase.
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int LW = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pulse_in,
    input  logic [LW-1:0] len,
    input  logic [LW-1:0] gap,
    input  logic          retrig,
    input  logic          ovf_clr,
    output logic          out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          ovf
);

    state_t        r_state;
    logic [LW-1:0] r_cnt;
    logic          r_out;
    logic          r_busy;
    logic          r_ovf;

    logic [LW-1:0] w_len1;
    logic [LW-1:0] w_gap1;
    logic          w_cnt_last;
    logic          w_pend_nz;
    logic          w_inc;
    logic          w_dec;
    logic          w_sat;
    logic          w_drop;
    logic [PW-1:0] w_pending;

    assign w_len1     = LW'(max1(32'(len)));
    assign w_gap1     = LW'(max1(32'(gap)));
    assign w_cnt_last = (r_cnt == LW'(1));
    assign w_pend_nz  = (w_pending != '0);

    // At the end of a gap a queued trigger is replayed; a same-cycle trigger
    // then takes its place in the queue, so inc and dec cancel.
    always_comb begin
        w_inc = 1'b0;
        w_dec = 1'b0;
        case (r_state)
            S_HIGH: w_inc = pulse_in & ~retrig;
            S_GAP: begin
                if (w_cnt_last) begin
                    w_dec = w_pend_nz;
                    w_inc = pulse_in & w_pend_nz;
                end else begin
                    w_inc = pulse_in & (~retrig | ~w_pend_nz);
                end
            end
            default: ;
        endcase
    end

    assign w_drop = w_inc & ~w_dec & w_sat;

    pend_counter #(.PW(PW)) u_pend (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_count (w_pending),
        .o_sat   (w_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (pulse_in) begin
                        r_state <= S_HIGH;
                        r_cnt   <= w_len1;
                        r_out   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (retrig && pulse_in) begin
                        r_cnt <= w_len1;
                    end else if (w_cnt_last) begin
                        r_state <= S_GAP;
                        r_cnt   <= w_gap1;
                        r_out   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - LW'(1);
                    end
                end
                S_GAP: begin
                    if (w_cnt_last) begin
                        if (w_pend_nz || pulse_in) begin
                            r_state <= S_HIGH;
                            r_cnt   <= w_len1;
                            r_out   <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - LW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out     = r_out;
    assign busy    = r_busy;
    assign pending = w_pending;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: two instances (PW=4 and PW=2) share stimulus and
// are tracked every cycle by a remaining-cycles model, plus literal scenarios.
module tb_pulse_stretcher;

    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pulse_in = 1'b0;
    logic [LW-1:0] len = 8'd1;
    logic [LW-1:0] gap = 8'd1;
    logic          retrig = 1'b0;
    logic          ovf_clr = 1'b0;

    logic       out0, busy0, ovf0;
    logic [3:0] pend0;
    logic       out1, busy1, ovf1;
    logic [1:0] pend1;

    int errors = 0;
    int checks = 0;

    // Model: remaining high cycles, remaining gap cycles, queued count, sticky ovf.
    int m_hi[2];
    int m_gap[2];
    int m_pend[2];
    bit m_ovf[2];
    int m_max[2] = '{15, 3};

    int rise0 = 0;
    int rise1 = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(.LW(LW), .PW(4)) u0 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .len(len), .gap(gap),
        .retrig(retrig), .ovf_clr(ovf_clr),
        .out(out0), .busy(busy0), .pending(pend0), .ovf(ovf0)
    );

    pulse_stretcher #(.LW(LW), .PW(2)) u1 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .len(len), .gap(gap),
        .retrig(retrig), .ovf_clr(ovf_clr),
        .out(out1), .busy(busy1), .pending(pend1), .ovf(ovf1)
    );

    always @(posedge out0) rise0++;
    always @(posedge out1) rise1++;

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    task automatic model_step(input int i);
        bit drop;
        drop = 1'b0;
        if (rst) begin
            m_hi[i] = 0; m_gap[i] = 0; m_pend[i] = 0; m_ovf[i] = 1'b0;
            return;
        end
        if (m_hi[i] > 0) begin
            if (retrig && pulse_in) begin
                m_hi[i] = eff(int'(len));
            end else begin
                if (!retrig && pulse_in) begin
                    if (m_pend[i] == m_max[i]) drop = 1'b1;
                    else m_pend[i]++;
                end
                m_hi[i]--;
                if (m_hi[i] == 0) m_gap[i] = eff(int'(gap));
            end
        end else if (m_gap[i] > 0) begin
            if (m_gap[i] == 1) begin
                m_gap[i] = 0;
                if (m_pend[i] > 0) begin
                    m_hi[i] = eff(int'(len));
                    if (!pulse_in) m_pend[i]--;
                end else if (pulse_in) begin
                    m_hi[i] = eff(int'(len));
                end
            end else begin
                m_gap[i]--;
                if (pulse_in) begin
                    if (retrig) begin
                        if (m_pend[i] == 0) m_pend[i] = 1;
                    end else if (m_pend[i] == m_max[i]) begin
                        drop = 1'b1;
                    end else begin
                        m_pend[i]++;
                    end
                end
            end
        end else if (pulse_in) begin
            m_hi[i] = eff(int'(len));
        end
        if (drop) m_ovf[i] = 1'b1;
        else if (ovf_clr) m_ovf[i] = 1'b0;
    endtask

    task automatic cmp_inst(input int i, input logic o, input logic b,
                            input logic [31:0] p, input logic ov);
        logic eo, eb;
        eo = (m_hi[i] > 0);
        eb = (m_hi[i] > 0) || (m_gap[i] > 0);
        checks++;
        if (o !== eo || b !== eb || p !== 32'(m_pend[i]) || ov !== m_ovf[i]) begin
            errors++;
            $display("FAIL model_cmp u%0d t=%0t: got out=%b busy=%b pend=%0d ovf=%b, need out=%b busy=%b pend=%0d ovf=%b",
                     i, $time, o, b, p, ov, eo, eb, m_pend[i], m_ovf[i]);
        end
    endtask

    always begin
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cmp_inst(0, out0, busy0, 32'(pend0), ovf0);
        cmp_inst(1, out1, busy1, 32'(pend1), ovf1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h need 'h%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // pat[k] drives the edge t+k; bit captured for cycle t+1+k, first cycle in the MSB.
    task automatic run_pat(input int n, input logic [15:0] pat,
                           output logic [15:0] vo, output logic [15:0] vb,
                           output logic [15:0] mvo, output int pk);
        vo = '0; vb = '0; mvo = '0; pk = 0;
        for (int k = 0; k < n; k++) begin
            pulse_in = pat[k];
            tick();
            vo  = {vo[14:0], out0};
            vb  = {vb[14:0], busy0};
            mvo = {mvo[14:0], (m_hi[0] > 0)};
            if (int'(pend0) > pk) pk = int'(pend0);
        end
        pulse_in = 1'b0;
    endtask

    logic [15:0] vo, vb, mvo;
    int          pk;
    int          w;

    initial begin
        tick();
        tick();
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            tick();
            chk("reset_idle.u0", {out0, busy0, pend0, ovf0}, 0);
            chk("reset_idle.u1", {out1, busy1, pend1, ovf1}, 0);
        end

        len = 8'd3; gap = 8'd2; retrig = 1'b0;
        run_pat(6, 16'b1, vo, vb, mvo, pk);
        chk("single.out", vo, 16'b111000);
        chk("single.busy", vb, 16'b111110);
        chk("single.model_out", mvo, 16'b111000);

        len = 8'd2; gap = 8'd1;
        run_pat(10, 16'b111, vo, vb, mvo, pk);
        chk("queue.out", vo, 16'b1101101100);
        chk("queue.model_out", mvo, 16'b1101101100);
        chk("queue.pend_peak", pk, 2);
        chk("queue.pend_end", pend0, 0);

        retrig = 1'b1; len = 8'd4; gap = 8'd1;
        run_pat(9, 16'b1001, vo, vb, mvo, pk);
        chk("retrig.out", vo, 16'b111111100);
        chk("retrig.busy", vb, 16'b111111110);
        chk("retrig.model_out", mvo, 16'b111111100);
        chk("retrig.pend_peak", pk, 0);

        retrig = 1'b0; len = 8'd0; gap = 8'd0;
        run_pat(6, 16'b11, vo, vb, mvo, pk);
        chk("len0.out", vo, 16'b101000);
        chk("len0.busy", vb, 16'b111100);

        len = 8'd10; gap = 8'd1;
        rise0 = 0; rise1 = 0;
        run_pat(6, 16'b11111, vo, vb, mvo, pk);
        chk("ovf.pend_sat_u1", pend1, 3);
        chk("ovf.set_u1", ovf1, 1);
        chk("ovf.pend_u0", pend0, 4);
        chk("ovf.clear_u0", ovf0, 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf.cleared_u1", ovf1, 0);
        w = 0;
        while ((busy0 || busy1) && w < 300) begin
            tick();
            w++;
        end
        chk("ovf.drain_timeout", {busy0, busy1}, 0);
        chk("ovf.emitted_u1", rise1, 4);
        chk("ovf.emitted_u0", rise0, 5);

        run_pat(3, 16'b11, vo, vb, mvo, pk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.u0", {out0, busy0, pend0}, 0);
        chk("midrst.u1", {out1, busy1, pend1}, 0);

        for (int k = 0; k < 4000; k++) begin
            pulse_in = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 10) len = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 99) < 10) gap = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 99) < 3) retrig = ~retrig;
            ovf_clr = ($urandom_range(0, 99) < 3);
            rst = ($urandom_range(0, 999) < 3);
            tick();
        end
        pulse_in = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
        for (int k = 0; k < 20; k++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
